// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: shifts one 24-bit RGB row at a time into a column shift-register
// chain, latches it and lights the matching row for a fixed dwell, cycling rows 0..7.
module led_matrix_scanner #(
  parameter int CLK_DIV     = 2,
  parameter int HOLD_CYCLES = 2000,
  parameter bit ROW_ACT_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [7:0][23:0] rows,
  output logic             ser_data,
  output logic             ser_clk,
  output logic             ser_latch,
  output logic             oe_n,
  output logic [7:0]       row_sel,
  output logic             busy,
  output logic             frame_done
);

  // state | meaning
  // IDLE  | stopped, columns blanked, no row selected
  // SHIFT | clocking 24 column bits of the next row into the chain
  // LATCH | storage strobe high, columns blanked, new row selected
  // DWELL | new row lit for HOLD_CYCLES
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DWELL} state_t;

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(CLK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [4:0]        LAST_BIT  = 5'd23;

  state_t             state_q, state_d;
  logic [2:0]         row_q, row_d;
  logic [4:0]         bit_q, bit_d;
  logic               half_q, half_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [7:0][23:0]   buf_q, buf_d;
  logic [2:0]         sel_row_q, sel_row_d;
  logic               sel_on_q, sel_on_d;
  logic [7:0]         row_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q     <= '0;
      bit_q     <= '0;
      half_q    <= 1'b0;
      div_q     <= '0;
      hold_q    <= '0;
      buf_q     <= '0;
      sel_row_q <= '0;
      sel_on_q  <= 1'b0;
    end else begin
      row_q     <= row_d;
      bit_q     <= bit_d;
      half_q    <= half_d;
      div_q     <= div_d;
      hold_q    <= hold_d;
      buf_q     <= buf_d;
      sel_row_q <= sel_row_d;
      sel_on_q  <= sel_on_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    bit_d      = bit_q;
    half_d     = half_q;
    div_d      = div_q;
    hold_d     = hold_q;
    buf_d      = buf_q;
    sel_row_d  = sel_row_q;
    sel_on_d   = sel_on_q;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          buf_d   = rows;
          row_d   = '0;
          bit_d   = '0;
          half_d  = 1'b0;
          div_d   = DIV_LOAD;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (div_q == '0) begin
          div_d = DIV_LOAD;
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            if (bit_q == LAST_BIT) begin
              bit_d     = '0;
              sel_row_d = row_q;
              sel_on_d  = 1'b1;
              state_d   = LATCH;
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      LATCH: begin
        if (div_q == '0) begin
          hold_d  = HOLD_LOAD;
          state_d = DWELL;
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      DWELL: begin
        if (hold_q == '0) begin
          row_d = row_q + 3'd1;
          // Re-snapshot only at the frame boundary so a frame never tears.
          if (row_q == 3'd7) begin
            frame_done = 1'b1;
            buf_d      = rows;
          end
          if (enable) begin
            bit_d   = '0;
            half_d  = 1'b0;
            div_d   = DIV_LOAD;
            state_d = SHIFT;
          end else begin
            sel_on_d = 1'b0;
            state_d  = IDLE;
          end
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // While the next row shifts in, the previous row stays lit from the storage register.
  assign busy      = (state_q != IDLE);
  assign ser_latch = (state_q == LATCH);
  assign ser_clk   = (state_q == SHIFT) && half_q;
  assign ser_data  = (state_q == SHIFT) ? buf_q[row_q][LAST_BIT - bit_q] : 1'b0;
  assign oe_n      = !((state_q == DWELL) || ((state_q == SHIFT) && sel_on_q));
  assign row_on    = sel_on_q ? (8'd1 << sel_row_q) : 8'd0;
  assign row_sel   = ROW_ACT_LOW ? ~row_on : row_on;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: random frames checked every cycle against a position-in-frame
// model, plus literal checks of reset, the first row word, frame timing and stop/reset.
module tb_led_matrix_scanner;
  localparam int CLK_DIV = 1;
  localparam int HOLD    = 4;
  localparam int ROW_P   = 48 * CLK_DIV + CLK_DIV + HOLD;
  localparam int FRAME_P = 8 * ROW_P;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic [7:0][23:0] rows = '0;
  logic             ser_data, ser_clk, ser_latch, oe_n, busy, frame_done;
  logic [7:0]       row_sel;

  int checks = 0;
  int errors = 0;

  led_matrix_scanner #(.CLK_DIV(CLK_DIV), .HOLD_CYCLES(HOLD), .ROW_ACT_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rows(rows),
    .ser_data(ser_data), .ser_clk(ser_clk), .ser_latch(ser_latch), .oe_n(oe_n),
    .row_sel(row_sel), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: scanning position is just a cycle count k since the first SHIFT cycle.
  int               m_active = 0;
  int               m_k = 0;
  logic [7:0][23:0] m_snap = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0;
      m_k      = 0;
      m_snap   = '0;
    end else if (m_active == 0) begin
      if (enable) begin
        m_active = 1;
        m_k      = 0;
        m_snap   = rows;
      end
    end else begin
      if (m_k % ROW_P == ROW_P - 1) begin
        if ((m_k / ROW_P) % 8 == 7) m_snap = rows;
        if (!enable) m_active = 0;
      end
      m_k++;
    end
  end

  logic       e_data, e_sclk, e_latch, e_oe, e_busy, e_fd, do_data, do_sclk;
  logic [7:0] e_sel, onehot;
  int         off, rw, bitn;
  logic       prev_sclk = 1'b0, prev_busy = 1'b0;
  logic [23:0] cap = '0;
  int         fd_count = 0, start_cyc = 0;

  always @(negedge clk) begin
    e_data = 1'b0; e_sclk = 1'b0; e_latch = 1'b0; e_oe = 1'b1; e_busy = 1'b0;
    e_fd = 1'b0; e_sel = 8'hFF; do_data = 1'b1; do_sclk = 1'b1;
    if (m_active != 0) begin
      off    = m_k % ROW_P;
      rw     = (m_k / ROW_P) % 8;
      e_busy = 1'b1;
      if (off < 48 * CLK_DIV) begin
        bitn   = off / (2 * CLK_DIV);
        e_sclk = ((off % (2 * CLK_DIV)) >= CLK_DIV);
        e_data = m_snap[rw][23 - bitn];
        if (m_k >= ROW_P) begin
          onehot = 8'd1 << ((rw + 7) % 8);
          e_sel  = ~onehot;
          e_oe   = 1'b0;
        end
      end else begin
        onehot  = 8'd1 << rw;
        e_sel   = ~onehot;
        do_data = 1'b0;
        if (off < 49 * CLK_DIV) begin
          e_latch = 1'b1;
        end else begin
          e_oe    = 1'b0;
          do_sclk = 1'b0;
          e_fd    = (off == ROW_P - 1) && (rw == 7);
        end
      end
    end
    chk("busy", busy, e_busy);
    chk("ser_latch", ser_latch, e_latch);
    chk("oe_n", oe_n, e_oe);
    chk("row_sel", row_sel, e_sel);
    chk("frame_done", frame_done, e_fd);
    if (do_sclk) chk("ser_clk", ser_clk, e_sclk);
    if (do_data) chk("ser_data", ser_data, e_data);
    if (ser_clk && !prev_sclk) cap = {cap[22:0], ser_data};
    prev_sclk = ser_clk;
    if (busy && !prev_busy) start_cyc = cyc;
    prev_busy = busy;
    if (frame_done) fd_count++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // kind 0: ser_latch, 1: frame_done, 2: not busy
  task automatic wait_for(input string name, input int kind, input int budget);
    int n = 0;
    @(negedge clk);
    while (!((kind == 0) ? ser_latch : (kind == 1) ? frame_done : !busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s waited=%0d cycles required<%0d", name, n, budget);
    end
  endtask

  task automatic rand_rows();
    for (int i = 0; i < 8; i++) rows[i] = 24'($urandom());
  endtask

  task automatic reset_literals(input string tag);
    #1;
    chk({tag, "_oe_n"}, oe_n, 1'b1);
    chk({tag, "_row_sel"}, row_sel, 8'hFF);
    chk({tag, "_ser_data"}, ser_data, 1'b0);
    chk({tag, "_ser_clk"}, ser_clk, 1'b0);
    chk({tag, "_ser_latch"}, ser_latch, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_frame_done"}, frame_done, 1'b0);
  endtask

  int fd1_cyc, fd_before;

  initial begin
    reset_literals("reset");
    step(3);
    rst_n = 1'b1;
    step(2);

    rand_rows();
    rows[0] = 24'hA5003C;
    enable  = 1'b1;
    wait_for("first_latch", 0, 200);
    chk("row0_word", cap, 24'hA5003C);
    chk("row0_latch_sel", row_sel, 8'hFE);

    wait_for("frame1_done", 1, FRAME_P + 10);
    chk("frame1_done_cycle", cyc - start_cyc + 1, 424);
    fd1_cyc = cyc;

    step(100);
    rand_rows();
    wait_for("frame2_done", 1, FRAME_P + 10);
    chk("frame_period", cyc - fd1_cyc, 424);

    step(3 * ROW_P + 10);
    enable    = 1'b0;
    fd_before = fd_count;
    wait_for("stop_idle", 2, 2 * ROW_P);
    chk("stop_row_sel", row_sel, 8'hFF);
    chk("stop_oe_n", oe_n, 1'b1);
    chk("stop_no_frame_done", fd_count, fd_before);

    step(5);
    rand_rows();
    enable = 1'b1;
    step(5 * ROW_P + 10);
    rst_n = 1'b0;
    reset_literals("midreset");
    step(3);
    rand_rows();
    rst_n = 1'b1;
    wait_for("restart_latch", 0, 200);
    chk("restart_word", cap, rows[0]);
    chk("restart_sel", row_sel, 8'hFE);
    wait_for("restart_frame_done", 1, FRAME_P + 10);
    chk("restart_fd_cycle", cyc - start_cyc + 1, 424);
    step(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout time=%0t required<500000", $time);
    $fatal(1, "simulation did not finish");
  end
endmodule
